// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : handshake_pkg
// Description : Shared defaults and the data-word type for the toggle
//               handshake slice.
// Revision    : 1.0 - initial release
// ============================================================================
package handshake_pkg;

  localparam int DEFAULT_WIDTH       = 7;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : handshake_pkg
`default_nettype wire

// File: rtl/handshake_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : Single-bit flop-chain synchronizer, DEPTH stages deep,
//               cleared asynchronously by reset_n.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit
  import handshake_pkg::*;
#(
  parameter int DEPTH = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // Shift the incoming bit one stage further along the chain each cycle.
  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d};
  end

  // Synchronizer flops; all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule : sync_bit
`default_nettype wire

// File: rtl/handshake.sv
`default_nettype none
// ============================================================================
// Module      : handshake
// Description : Toggle (2-phase) req/ack handshake moving WIDTH-bit words
//               from a source side to a destination side. Each control bit
//               crosses through a SYNC_STAGES-deep sync_bit chain; the data
//               word rides in a holding register that stays frozen until the
//               ack has returned.
//               Optional macro HANDSHAKE_ASSERT_EN adds concurrent assertions
//               (no logic change).
// Revision    : 1.0 - initial release
// ============================================================================
module handshake
  import handshake_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             new_data_s,
  input  logic [WIDTH-1:0] data_in_s,
  output logic             send_s,
  output logic             capture_d,
  output logic [WIDTH-1:0] data_out_d
);

  // Source side state
  logic             req_q,  req_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             ack_sync;
  logic             accept;

  // Destination side state
  logic             ack_q,  ack_d;
  logic             cap_q,  cap_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             req_sync;
  logic             new_req;

  // Source is idle once the returned ack matches the req it last toggled.
  assign send_s = (req_q == ack_sync);
  assign accept = new_data_s & send_s;

  // Source next state: latch the word and toggle req on accept only.
  always_comb begin
    req_d  = req_q ^ accept;
    hold_d = accept ? data_in_s : hold_q;
  end

  // Source registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      req_q  <= req_d;
      hold_q <= hold_d;
    end
  end

  // req crosses into the destination side.
  sync_bit #(.DEPTH(SYNC_STAGES)) u_req_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (req_q),
    .q       (req_sync)
  );

  // Destination next state: a req edge loads the word, pulses capture and
  // toggles ack (ack simply follows the synchronized req).
  always_comb begin
    new_req = req_sync ^ ack_q;
    ack_d   = req_sync;
    cap_d   = new_req;
    dout_d  = new_req ? hold_q : dout_q;
  end

  // Destination registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q  <= 1'b0;
      cap_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      ack_q  <= ack_d;
      cap_q  <= cap_d;
      dout_q <= dout_d;
    end
  end

  // ack crosses back into the source side.
  sync_bit #(.DEPTH(SYNC_STAGES)) u_ack_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (ack_q),
    .q       (ack_sync)
  );

  assign capture_d  = cap_q;
  assign data_out_d = dout_q;

`ifdef HANDSHAKE_ASSERT_EN
  // Capture is a single-cycle pulse.
  a_cap_single: assert property (@(posedge clk) disable iff (!reset_n)
    capture_d |=> !capture_d);

  // send_s only drops because a word was accepted on the previous edge.
  a_send_fall: assert property (@(posedge clk) disable iff (!reset_n)
    $fell(send_s) |-> $past(new_data_s && send_s));

  // Delivered data only moves together with a capture pulse.
  a_dout_stable: assert property (@(posedge clk) disable iff (!reset_n)
    !capture_d |-> $stable(data_out_d));
`else
  // Assertions not compiled in this build.
`endif

endmodule : handshake
`default_nettype wire

// File: tb/tb_handshake.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake
// Description : Directed self-checking bench for handshake. Two instances
//               share the same stimulus: SYNC_STAGES=2 and SYNC_STAGES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake;

  localparam int W = 7;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b0;
  logic         new_data_s = 1'b0;
  logic [W-1:0] data_in_s  = '0;

  logic         send2, cap2, send3, cap3;
  logic [W-1:0] dout2, dout3;
  logic [W-1:0] last2, last3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  handshake #(.WIDTH(W), .SYNC_STAGES(2)) u_dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .new_data_s (new_data_s),
    .data_in_s  (data_in_s),
    .send_s     (send2),
    .capture_d  (cap2),
    .data_out_d (dout2)
  );

  handshake #(.WIDTH(W), .SYNC_STAGES(3)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .new_data_s (new_data_s),
    .data_in_s  (data_in_s),
    .send_s     (send3),
    .capture_d  (cap3),
    .data_out_d (dout3)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transfer; j counts edges after the accept edge k.
  task automatic single_xfer(input logic [W-1:0] v);
    data_in_s  = v;
    new_data_s = 1'b1;
    tick();
    new_data_s = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) tick();
      check_eq("x2_cap",  cap2,  j == 3);
      check_eq("x2_send", send2, j >= 5);
      check_eq("x2_dout", dout2, (j >= 3) ? v : last2);
      check_eq("x3_cap",  cap3,  j == 4);
      check_eq("x3_send", send3, j >= 7);
      check_eq("x3_dout", dout3, (j >= 4) ? v : last3);
    end
    last2 = v;
    last3 = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    last2 = '0;
    last3 = '0;

    // Reset values while reset is held.
    #1;
    check_eq("rst_send2", send2, 1);
    check_eq("rst_cap2",  cap2,  0);
    check_eq("rst_dout2", dout2, 0);
    check_eq("rst_send3", send3, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle: nothing offered for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_send", send2, 1);
      check_eq("idle_cap",  cap2,  0);
      check_eq("idle_dout", dout2, 0);
    end

    // Single words, including all-ones boundary.
    single_xfer(7'h2A);
    single_xfer(7'h7F);

    // Offers of 0x55 while busy must be dropped.
    data_in_s  = 7'h33;
    new_data_s = 1'b1;
    tick();
    data_in_s = 7'h55;
    for (int j = 1; j <= 12; j++) begin
      new_data_s = (j <= 3);
      tick();
      check_eq("ign_cap2",  cap2,  j == 3);
      check_eq("ign_dout2", dout2, (j >= 3) ? 7'h33 : last2);
      check_eq("ign_cap3",  cap3,  j == 4);
      check_eq("ign_dout3", dout3, (j >= 4) ? 7'h33 : last3);
    end
    last2 = 7'h33;
    last3 = 7'h33;

    // Streaming: data_in_s = i before edge i; accepts at edges 0,6,..,96.
    new_data_s = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      data_in_s = W'(i);
      tick();
      check_eq("str_cap",  cap2,  (i % 6 == 3));
      check_eq("str_send", send2, (i % 6 == 5));
      if (i % 6 == 3) check_eq("str_dout", dout2, i - 3);
    end
    new_data_s = 1'b0;
    for (int i = 101; i <= 112; i++) begin
      tick();
      check_eq("str_tail_cap",  cap2,  0);
      check_eq("str_tail_send", send2, 1);
      check_eq("str_tail_dout", dout2, 96);
    end
    check_eq("str_dout3", dout3, 96);
    last2 = 7'd96;
    last3 = 7'd96;

    // Reset one cycle after accepting 0x11.
    data_in_s  = 7'h11;
    new_data_s = 1'b1;
    tick();
    new_data_s = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("mrst_send2", send2, 1);
    check_eq("mrst_cap2",  cap2,  0);
    check_eq("mrst_dout2", dout2, 0);
    check_eq("mrst_dout3", dout3, 0);
    tick();
    tick();
    reset_n = 1'b1;
    check_eq("mrst_rel_send2", send2, 1);
    check_eq("mrst_rel_send3", send3, 1);
    for (int j = 0; j < 10; j++) begin
      tick();
      check_eq("mrst_cap2",  cap2,  0);
      check_eq("mrst_cap3",  cap3,  0);
      check_eq("mrst_dout2", dout2, 0);
      check_eq("mrst_send2", send2, 1);
    end
    last2 = '0;
    last3 = '0;
    single_xfer(7'h4C);
    single_xfer(7'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_handshake
`default_nettype wire
